// File: rtl/branch_pkg.sv
// Shared types, default sizes and the condition-code evaluator for the
// branch resolver.
package branch_pkg;

    typedef enum logic [2:0] {
        COND_NE     = 3'b000,
        COND_EQ     = 3'b001,
        COND_LT     = 3'b010,
        COND_LE     = 3'b011,
        COND_ALWAYS = 3'b100,
        COND_GE     = 3'b101,
        COND_GT     = 3'b110,
        COND_NEVER  = 3'b111
    } cond_e;

    localparam int DEF_PC_W      = 10;
    localparam int DEF_IMM_W     = 5;
    localparam int DEF_TBL_DEPTH = 32;
    localparam int DEF_RAS_DEPTH = 4;

    // Resolve a condition code against the ALU compare results.
    function automatic logic cond_eval(cond_e cond, logic equal, logic less);
        logic taken;
        taken = 1'b0;
        case (cond)
            COND_NE:     taken = !equal;
            COND_EQ:     taken = equal;
            COND_LT:     taken = less;
            COND_LE:     taken = less | equal;
            COND_ALWAYS: taken = 1'b1;
            COND_GE:     taken = !less;
            COND_GT:     taken = !less & !equal;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_unit_v2_if.sv
// Decode-side bus of the branch resolver: instruction strobes, ALU flags,
// target-table write port, resolved target and stack status.
interface branch_unit_v2_if
    import branch_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int IMM_W = DEF_IMM_W
) ();

    logic             flag_we;
    logic [2:0]       flag_in;
    logic             equal;
    logic             less;
    logic             branch_instr;
    logic             call_instr;
    logic             ret_instr;
    logic [IMM_W-1:0] immediate;
    logic [PC_W-1:0]  pc;
    logic             tbl_we;
    logic [IMM_W-1:0] tbl_waddr;
    logic [PC_W-1:0]  tbl_wdata;
    logic [PC_W-1:0]  address;
    logic             branch;
    logic             ras_full;
    logic             ras_empty;
    logic             ras_err;

    modport master (
        output flag_we, flag_in, equal, less,
        output branch_instr, call_instr, ret_instr, immediate, pc,
        output tbl_we, tbl_waddr, tbl_wdata,
        input  address, branch, ras_full, ras_empty, ras_err
    );

    modport slave (
        input  flag_we, flag_in, equal, less,
        input  branch_instr, call_instr, ret_instr, immediate, pc,
        input  tbl_we, tbl_waddr, tbl_wdata,
        output address, branch, ras_full, ras_empty, ras_err
    );

endinterface

// File: rtl/branch_ras.sv
// Circular return-address stack. Overflow overwrites the oldest entry,
// underflow is refused; both latch a sticky error until reset.
module branch_ras
    import branch_pkg::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty,
    output logic            err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] sp;
    logic [CNT_W-1:0] count;
    logic             err_q;

    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);
    assign err   = err_q;
    assign top   = mem[sp - PTR_ONE];

    // Entry storage; a push always lands in the slot the pointer names, which
    // is the oldest entry once the stack has wrapped.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp] <= push_data;
        end
    end

    // Pointer, occupancy and sticky error bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp    <= '0;
            count <= '0;
            err_q <= 1'b0;
        end else if (push) begin
            sp <= sp + PTR_ONE;
            if (full) begin
                err_q <= 1'b1;
            end else begin
                count <= count + CNT_ONE;
            end
        end else if (pop) begin
            if (empty) begin
                err_q <= 1'b1;
            end else begin
                sp    <= sp - PTR_ONE;
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/branch_unit_v2.sv
// Branch resolver: flag register, programmable target table, call/return
// stack and the priority decode that feeds the PC mux in the same cycle.
module branch_unit_v2
    import branch_pkg::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int IMM_W     = DEF_IMM_W,
    parameter int TBL_DEPTH = DEF_TBL_DEPTH,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input logic              clk,
    input logic              reset,
    branch_unit_v2_if.slave  bus
);

    localparam int TBL_AW = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1;
    localparam logic [IMM_W:0]  TBL_LIMIT = (IMM_W+1)'(TBL_DEPTH);
    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);

    cond_e           flag_q;
    logic [PC_W-1:0] tgt_tbl [TBL_DEPTH];

    logic            wr_valid;
    logic            rd_valid;
    logic [PC_W-1:0] tbl_rd;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    logic            branch_c;
    logic [PC_W-1:0] address_c;

    assign wr_valid = ({1'b0, bus.tbl_waddr} < TBL_LIMIT);
    assign rd_valid = ({1'b0, bus.immediate} < TBL_LIMIT);
    assign tbl_rd   = tgt_tbl[bus.immediate[TBL_AW-1:0]];

    // Condition-code register; a same-cycle branch still sees the old code.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= COND_NE;
        end else if (bus.flag_we) begin
            flag_q <= cond_e'(bus.flag_in);
        end
    end

    // Target table; writes outside the table are dropped, and a same-cycle
    // read of the written index returns the previous entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                tgt_tbl[i] <= '0;
            end
        end else if (bus.tbl_we && wr_valid) begin
            tgt_tbl[bus.tbl_waddr[TBL_AW-1:0]] <= bus.tbl_wdata;
        end
    end

    // Priority decode ret > call > branch, producing target, take and stack ops.
    always_comb begin
        branch_c  = 1'b0;
        address_c = '0;
        push      = 1'b0;
        pop       = 1'b0;
        if (!reset) begin
            if (bus.ret_instr) begin
                pop = 1'b1;
                if (!ras_empty) begin
                    branch_c  = 1'b1;
                    address_c = ras_top;
                end
            end else if (bus.call_instr) begin
                push = 1'b1;
                if (rd_valid) begin
                    branch_c  = 1'b1;
                    address_c = tbl_rd;
                end
            end else if (bus.branch_instr) begin
                if (rd_valid) begin
                    branch_c  = cond_eval(flag_q, bus.equal, bus.less);
                    address_c = tbl_rd;
                end
            end else if (rd_valid) begin
                address_c = tbl_rd;
            end
        end
    end

    assign bus.branch    = branch_c;
    assign bus.address   = address_c;
    assign bus.ras_empty = ras_empty;

    branch_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (bus.pc + PC_ONE),
        .top       (ras_top),
        .full      (bus.ras_full),
        .empty     (ras_empty),
        .err       (bus.ras_err)
    );

endmodule

// File: doc/branch_unit_v2.md
Name: branch_unit_v2

Overview:
Parametrised next-generation branch resolver for the correction-decoder core.
- Replaces the hard-wired immediate-to-target mapping with a programmable target table.
- Extends the 3-bit flag register to the full eight condition codes.
- Adds a call/return address stack so decoder subroutines can be shared.
- Sits between instruction decode and the PC register; the PC mux consumes `branch`/`address` in the same cycle.

Parameters:
PC_W, 10, width of program counter and branch targets
IMM_W, 5, width of branch immediate / target-table index
TBL_DEPTH, 32, target-table entries (must be <= 2**IMM_W)
RAS_DEPTH, 4, return-address-stack entries (power of two, >= 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flag_we  in  1  load flag register from flag_in at next posedge
flag_in  in  3  new condition code
equal  in  1  ALU equal result, current cycle
less  in  1  ALU less-than result, current cycle
branch_instr  in  1  current instruction is conditional branch
call_instr  in  1  current instruction is call
ret_instr  in  1  current instruction is return
immediate  in  IMM_W  target-table index
pc  in  PC_W  PC of current instruction
tbl_we  in  1  target-table write enable
tbl_waddr  in  IMM_W  target-table write index
tbl_wdata  in  PC_W  target-table write data
address  out  PC_W  branch target
branch  out  1  take branch this cycle
ras_full  out  1  stack holds RAS_DEPTH entries
ras_empty  out  1  stack holds zero entries
ras_err  out  1  sticky overflow/underflow flag

Behaviour:
Reset values:
- Flag register 3'b000.
- All table entries 0.
- RAS count 0; ras_empty=1, ras_full=0, ras_err=0.
- While reset is high, branch=0 and address=0, regardless of inputs.

Condition codes (flag register):
- 000 NE = !equal; 001 EQ = equal; 010 LT = less; 011 LE = less|equal.
- 100 ALWAYS = 1; 101 GE = !less; 110 GT = !less&!equal; 111 NEVER = 0.

Decode and outputs:
- `branch` and `address` are combinational from current inputs and registered state, with zero cycles of latency.
- Instruction priority: ret_instr > call_instr > branch_instr. Lower-priority strobes are ignored when a higher one is asserted.
- branch_instr: address = table[immediate]; branch = condition(flag register).
- call_instr: branch=1; address = table[immediate]; push pc+1 (mod 2**PC_W) at posedge.
- ret_instr, stack non-empty: branch=1; address = top-of-stack; pop at posedge.
- ret_instr, stack empty: branch=0, address=0, no pop, ras_err set at posedge.
- No instruction strobe: branch=0, address = table[immediate].
- immediate >= TBL_DEPTH: address=0, and branch is forced to 0.

Write/read ordering:
- Flag write and branch in the same cycle: the branch evaluates the OLD flag value. The new value is visible the next cycle.
- Table write and read of the same index in the same cycle: the read returns the OLD entry.
- tbl_waddr >= TBL_DEPTH: the write is ignored.

Return-address stack:
- Circular buffer with a top pointer and a count.
- Call when full: the push overwrites the oldest entry (pointer wraps), count stays RAS_DEPTH, ras_err set.
- Push and pop are mutually exclusive because of the instruction priority.
- ras_err is sticky and clears only on reset.
- Reset mid-sequence: discards all stack contents; table and flags are reset as well.

Decomposition:
branch_pkg:
- cond_e enum (COND_NE..COND_NEVER, 3 bits).
- Default parameter constants.
- Function cond_eval(cond_e, equal, less).

Sub-module branch_ras (params PC_W, RAS_DEPTH):
- Ports: push, pop, push_data, top, full, empty, err.
- Owns pointer, count and overflow/underflow logic.

branch_unit_v2 owns the flag register, target table and priority decode.

Test Plan:
1. Reset, then tbl_we idx 1 <- 16. Next cycle branch_instr, immediate=1, flag=000, equal=0 -> branch=1, address=16. Same with equal=1 -> branch=0.
2. Cycle A: flag_we with flag_in=110 and branch_instr, flag=000, equal=0, less=0 -> branch=1 (old NE). Cycle A+1: same operands -> branch=1 (GT); less=1 -> branch=0.
3. Sweep all 8 condition codes x {equal, less} combinations -> branch matches the truth table exactly; 111 is never taken, 100 is always taken.
4. call at pc=40, immediate=2 (table=29) -> branch=1, address=29. Then ret -> branch=1, address=41, ras_empty=1 afterwards.
5. Five calls (RAS_DEPTH=4) at pc=10,20,30,40,50 -> ras_full=1, ras_err=1. Four rets return 51,41,31,21. Fifth ret -> branch=0, address=0, ras_empty=1, ras_err stays 1.
6. Same-cycle table write idx 3 (99->7) with branch_instr immediate=3, flag=100 -> address=99; next cycle -> address=7. Then assert reset mid-stack -> table=0, ras_empty=1, ras_err=0.
